// File: rtl/nios_dut_pio_in_cond.sv
// Input conditioning for a PIO input port: two-flop synchronizer, per-bit debounce,
// change pulse and optional sticky rising-edge flags (NIOS_DUT_PIO_EDGE_CAPTURE_EN).
module nios_dut_pio_in_cond #(
    parameter int WIDTH           = 20,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] data_out,
    output logic             changed,
    input  logic [WIDTH-1:0] edge_clr,
    output logic [WIDTH-1:0] edge_flags,
    output logic             irq
);

    localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] s1_reg;
    logic [WIDTH-1:0] s2_reg;
    logic [WIDTH-1:0] data_reg;
    logic [WIDTH-1:0] update;
    logic             changed_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_reg <= '0;
            s2_reg <= '0;
        end else begin
            s1_reg <= raw_in;
            s2_reg <= s1_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic [15:0] cnt_reg;
            logic        bit_reg;
            logic        mismatch;

            assign mismatch    = (s2_reg[gi] != bit_reg);
            assign update[gi]  = mismatch && (cnt_reg >= CNT_MAX);
            assign data_reg[gi] = bit_reg;

            // Count only while mismatched; any match restarts the run from zero.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_reg <= '0;
                    bit_reg <= 1'b0;
                end else if (!mismatch) begin
                    cnt_reg <= '0;
                end else if (cnt_reg >= CNT_MAX) begin
                    cnt_reg <= '0;
                    bit_reg <= s2_reg[gi];
                end else begin
                    cnt_reg <= cnt_reg + 16'd1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            changed_reg <= 1'b0;
        end else begin
            changed_reg <= |update;
        end
    end

    assign data_out = data_reg;
    assign changed  = changed_reg;

`ifdef NIOS_DUT_PIO_EDGE_CAPTURE_EN
    logic [WIDTH-1:0] flags_reg;
    logic [WIDTH-1:0] armed_reg;
    logic [1:0]       prime_reg;

    // A bit only arms once the synchronizer holds real samples and a 0 is settled,
    // so inputs already high at reset release never raise a flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_reg <= '0;
            armed_reg <= '0;
            prime_reg <= '0;
        end else begin
            prime_reg <= {prime_reg[0], 1'b1};
            armed_reg <= armed_reg | ({WIDTH{prime_reg[1]}} & ~s2_reg & ~data_reg);
            flags_reg <= (flags_reg & ~edge_clr) | (update & s2_reg & armed_reg);
        end
    end

    assign edge_flags = flags_reg;
    assign irq        = |flags_reg;
`else
    logic unused_edge_clr;

    assign unused_edge_clr = ^edge_clr;
    assign edge_flags      = '0;
    assign irq             = 1'b0;
`endif

endmodule

// File: tb/tb_nios_dut_pio_in_cond.sv
// Bench for nios_dut_pio_in_cond: directed vector table, hand-written timing
// sequences and randomized toggling against a run-length reference model.
module tb_nios_dut_pio_in_cond;

    localparam int W = 20;
    localparam int D = 4;
`ifdef NIOS_DUT_PIO_EDGE_CAPTURE_EN
    localparam bit FLAG_EN = 1'b1;
`else
    localparam bit FLAG_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] raw_in;
    logic [W-1:0] edge_clr;
    logic [W-1:0] data_out;
    logic [W-1:0] edge_flags;
    logic         changed;
    logic         irq;

    nios_dut_pio_in_cond #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .raw_in    (raw_in),
        .data_out  (data_out),
        .changed   (changed),
        .edge_clr  (edge_clr),
        .edge_flags(edge_flags),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: synchronizer as a two-deep delay line, debounce as a
    // run length of consecutive mismatching samples.
    logic [W-1:0] m_s1, m_s2, m_out, m_flags, m_armed;
    logic         m_changed;
    int           m_run[W];
    int           m_edges;

    function automatic void check(string name, logic [W-1:0] act, logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endfunction

    function automatic void model_reset();
        m_s1 = '0; m_s2 = '0; m_out = '0; m_flags = '0; m_armed = '0;
        m_changed = 1'b0; m_edges = 0;
        for (int i = 0; i < W; i++) m_run[i] = 0;
    endfunction

    function automatic void model_tick();
        logic [W-1:0] s2_old  = m_s2;
        logic [W-1:0] out_old = m_out;
        logic [W-1:0] set     = '0;
        logic         any     = 1'b0;
        m_s2 = m_s1;
        m_s1 = raw_in;
        for (int i = 0; i < W; i++) begin
            if (s2_old[i] != out_old[i]) begin
                m_run[i] = m_run[i] + 1;
                if (m_run[i] == D) begin
                    m_out[i] = s2_old[i];
                    m_run[i] = 0;
                    any = 1'b1;
                    if (s2_old[i] && m_armed[i]) set[i] = 1'b1;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        if (FLAG_EN) begin
            m_flags = (m_flags & ~edge_clr) | set;
            if (m_edges >= 2) m_armed = m_armed | (~s2_old & ~out_old);
        end
        m_changed = any;
        m_edges++;
    endfunction

    task automatic step();
        @(posedge clk);
        model_tick();
        #1;
        check("data_out", data_out, m_out);
        check("changed", W'(changed), W'(m_changed));
        check("edge_flags", edge_flags, m_flags);
        check("irq", W'(irq), W'(|m_flags));
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("rst_data_out", data_out, '0);
        check("rst_changed", W'(changed), '0);
        check("rst_flags", edge_flags, '0);
        check("rst_irq", W'(irq), '0);
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [W-1:0] raw;
        int           hold;
        logic [W-1:0] exp_out;
        int           exp_pulses;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int pulses;
        reset_n  = 1'b1;
        raw_in   = '0;
        edge_clr = '0;
        model_reset();

        vecs[0] = '{20'h00001,  8, 20'h00001, 1};
        vecs[1] = '{20'h00009,  3, 20'h00001, 0};  // 3-cycle glitch on bit 3
        vecs[2] = '{20'h00001, 10, 20'h00001, 0};
        vecs[3] = '{20'h00009,  4, 20'h00001, 0};  // 4-cycle pulse on bit 3
        vecs[4] = '{20'h00001, 10, 20'h00001, 2};
        vecs[5] = '{20'hFFFFF,  8, 20'hFFFFF, 1};
        vecs[6] = '{20'h00000,  8, 20'h00000, 1};

        apply_reset();
        for (int v = 0; v < 7; v++) begin
            raw_in = vecs[v].raw;
            pulses = 0;
            for (int c = 0; c < vecs[v].hold; c++) begin
                step();
                if (changed === 1'b1) pulses++;
            end
            check($sformatf("vec%0d_out", v), data_out, vecs[v].exp_out);
            check($sformatf("vec%0d_pulses", v), W'(pulses), W'(vecs[v].exp_pulses));
            $display("vec %0d raw=%h hold=%0d data_out=%h pulses=%0d", v, vecs[v].raw,
                     vecs[v].hold, data_out, pulses);
        end

        // Exact latency from reset: first edge after release is edge 0.
        apply_reset();
        raw_in = 20'h00001;
        for (int e = 0; e < 8; e++) begin
            step();
            check($sformatf("lat_e%0d_out", e), data_out, (e >= 5) ? W'(1) : W'(0));
            check($sformatf("lat_e%0d_chg", e), W'(changed), (e == 5) ? W'(1) : W'(0));
        end
        $display("latency seq done data_out=%h", data_out);

        // Reset mid-count on bit 0 while bit 1 is already accepted high.
        raw_in = 20'h00002;
        for (int c = 0; c < 10; c++) step();
        check("pre_mid_out", data_out, 20'h00002);
        raw_in = 20'h00003;
        for (int c = 0; c < 4; c++) step();
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_out", data_out, '0);
        check("mid_rst_chg", W'(changed), '0);
        check("mid_rst_flags", edge_flags, '0);
        check("mid_rst_irq", W'(irq), '0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        model_reset();
        for (int e = 1; e <= 8; e++) begin
            step();
            check($sformatf("rel_e%0d_out", e), data_out, (e >= 2 + D) ? W'(3) : W'(0));
        end
        check("no_flag_from_reset_high", edge_flags, '0);
        $display("mid-count reset seq done data_out=%h flags=%h", data_out, edge_flags);

        // Edge flag set, clear, and set-wins-over-clear.
        raw_in = '0;
        for (int c = 0; c < 10; c++) step();
        raw_in = 20'h00080;
        for (int c = 0; c < 6; c++) step();
        check("flag_set", edge_flags, FLAG_EN ? W'(20'h00080) : W'(0));
        check("flag_irq", W'(irq), W'(FLAG_EN));
        edge_clr = 20'h00080;
        step();
        edge_clr = '0;
        check("flag_clr", edge_flags, '0);
        raw_in = '0;
        for (int c = 0; c < 8; c++) step();
        raw_in = 20'h00080;
        for (int c = 0; c < 5; c++) step();
        edge_clr = 20'h00080;
        step();
        edge_clr = '0;
        check("set_wins_out", data_out, 20'h00080);
        check("set_wins_flag", edge_flags, FLAG_EN ? W'(20'h00080) : W'(0));
        $display("edge flag seq done flags=%h irq=%b", edge_flags, irq);

        // Random toggling with random clear strobes.
        for (int c = 0; c < 600; c++) begin
            raw_in   = raw_in ^ (W'($urandom) & W'($urandom) & W'($urandom));
            edge_clr = W'($urandom) & W'($urandom);
            step();
            if (!FLAG_EN) check("rand_flags_zero", edge_flags | W'(irq), '0);
        end
        $display("random phase done data_out=%h flags=%h", data_out, edge_flags);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
